// File: rtl/chunk_pkg.sv
// chunk_pkg: definitions shared by both ends of the chunked link so that they agree on chunk order and counter width
package chunk_pkg;
    // Returns the chunk counter width: at least 1 bit, so that L==M still elaborates.
    function automatic int chunk_cnt_w(input int l, input int m);
        return ($clog2(l / m) < 1) ? 1 : $clog2(l / m);
    endfunction
endpackage

// File: rtl/dechunker.sv
// dechunker: reassembles M-bit chunks (first chunk is the MSB) into L-bit words
//   clk      in  1  clock, rising edge
//   reset    in  1  asynchronous active-low reset
//   d        in  M  incoming chunk, sampled when valid
//   valid    in  1  d carries a chunk this cycle
//   sync     in  1  with valid: this chunk starts a new word
//   data_out out L  last completed word, held until the next word completes
//   strobe   out 1  one-cycle pulse when data_out updates
//   error    out 1  sticky: a partial word was dropped by sync
//   busy     out 1  a partial word is held
module dechunker
    import chunk_pkg::*;
#(
    parameter int L = 8,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [M-1:0] d,
    input  logic         valid,
    input  logic         sync,
    output logic [L-1:0] data_out,
    output logic         strobe,
    output logic         error,
    output logic         busy
);
    localparam int NR = L / M;
    localparam int CW = chunk_cnt_w(L, M);
    localparam logic [CW-1:0] CNT_LAST = CW'(NR - 1);
    // After a sync chunk the word holds one chunk, unless one chunk is a whole word.
    localparam logic [CW-1:0] CNT_SYNC = (NR == 1) ? '0 : CW'(1);

    if (L % M != 0) begin : g_bad_ratio
        $fatal(1, "dechunker: L must be a multiple of M");
    end

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [L-1:0]   sr_q, sr_d;
    logic [L+M-1:0] shifted;
    logic           last, done;

    // Concatenate-then-truncate keeps the shift legal even when L==M.
    assign shifted = {sr_q, d};
    assign sr_d    = shifted[L-1:0];
    assign last    = (cnt_q == CNT_LAST);
    assign done    = valid && (sync ? (NR == 1) : last);
    assign cnt_d   = !valid ? cnt_q : sync ? CNT_SYNC : last ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            sr_q     <= '0;
            data_out <= '0;
            strobe   <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            strobe <= done;
            busy   <= (cnt_d != '0);
            if (valid) sr_q <= sr_d;
            if (done) data_out <= sr_d;
            if (valid && sync && cnt_q != '0) error <= 1'b1;
        end
    end
endmodule
